// File: rtl/bus_reg_pkg.sv
// Shared types for the Bus8 register bank: per-register access modes and mode lookup.
package bus_reg_pkg;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_WO  = 2'd2,
    REG_W1C = 2'd3
  } reg_mode_t;

  // Upper bound on bank size; mode vectors are widened to this before lookup.
  localparam int MAX_REGS = 256;

  function automatic reg_mode_t reg_mode(input logic [2*MAX_REGS-1:0] modes, input int idx);
    return reg_mode_t'(modes[2*idx +: 2]);
  endfunction

endpackage

// File: rtl/bus_reg_cell.sv
// One bank register: storage, W1C sticky-set merge and write strobe; update and strobe 1 cycle after write.
// No backpressure: a write is taken whenever wr_en_i is high.
module bus_reg_cell
  import bus_reg_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter reg_mode_t        MODE  = REG_RW,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [WIDTH-1:0] set_i,
  output logic [WIDTH-1:0] val_o,
  output logic             wr_stb_o
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             stb_q, stb_d;

  always_comb begin
    reg_d = reg_q;
    unique case (MODE)
      REG_RW, REG_WO: begin
        if (wr_en_i) reg_d = wr_data_i;
      end
      // Set is OR-ed after the clear so a same-cycle set of a cleared bit wins.
      REG_W1C: begin
        reg_d = (reg_q & ~(wr_en_i ? wr_data_i : {WIDTH{1'b0}})) | set_i;
      end
      default: reg_d = reg_q;
    endcase
  end

  assign stb_d = wr_en_i && (MODE != REG_RO);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= INIT;
      stb_q <= 1'b0;
    end else begin
      reg_q <= reg_d;
      stb_q <= stb_d;
    end
  end

  assign val_o    = (MODE == REG_RO) ? {WIDTH{1'b0}} : reg_q;
  assign wr_stb_o = stb_q;

endmodule

// File: rtl/bus_reg_bank_n.sv
// Parametrised Bus8 register bank; reads return data+DV 1 cycle after CS, writes land 1 cycle later.
// No backpressure (one transaction per CS cycle); define BUS_REG_BANK_ERR_EN to add the o_Bus_Err output.
module bus_reg_bank_n
  import bus_reg_pkg::*;
#(
  parameter int                           WIDTH    = 8,
  parameter int                           NUM_REGS = 8,
  parameter int                           ADDR_W   = 4,
  parameter logic [2*NUM_REGS-1:0]        REG_MODE = '0,
  parameter logic [NUM_REGS*WIDTH-1:0]    INIT     = '0
) (
  input  logic                      i_Bus_Clk,
  input  logic                      i_Bus_Rst_L,
  input  logic                      i_Bus_CS,
  input  logic                      i_Bus_Wr_Rd_n,
  input  logic [ADDR_W-1:0]         i_Bus_Addr8,
  input  logic [WIDTH-1:0]          i_Bus_Wr_Data,
  output logic [WIDTH-1:0]          o_Bus_Rd_Data,
  output logic                      o_Bus_Rd_DV,
  input  logic [NUM_REGS*WIDTH-1:0] i_Reg,
  input  logic [NUM_REGS*WIDTH-1:0] i_Set,
  output logic [NUM_REGS*WIDTH-1:0] o_Reg,
`ifdef BUS_REG_BANK_ERR_EN
  output logic                      o_Bus_Err,
`endif
  output logic [NUM_REGS-1:0]       o_Wr_Stb
);

  localparam logic [2*MAX_REGS-1:0] MODE_EXT = (2*MAX_REGS)'(REG_MODE);

  logic [NUM_REGS-1:0] wr_en;
  logic [WIDTH-1:0]    cell_val [NUM_REGS];
  logic [WIDTH-1:0]    rd_val;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_dv_q, rd_dv_d;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign wr_en[g] = i_Bus_CS && i_Bus_Wr_Rd_n && (i_Bus_Addr8 == ADDR_W'(g));

    bus_reg_cell #(
      .WIDTH (WIDTH),
      .MODE  (reg_mode(MODE_EXT, g)),
      .INIT  (INIT[g*WIDTH +: WIDTH])
    ) u_cell (
      .clk_i     (i_Bus_Clk),
      .rst_ni    (i_Bus_Rst_L),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (i_Bus_Wr_Data),
      .set_i     (i_Set[g*WIDTH +: WIDTH]),
      .val_o     (cell_val[g]),
      .wr_stb_o  (o_Wr_Stb[g])
    );

    assign o_Reg[g*WIDTH +: WIDTH] = cell_val[g];
  end

  // Unmapped addresses fall through with rd_val = 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_Bus_Addr8 == ADDR_W'(i)) begin
        unique case (reg_mode(MODE_EXT, i))
          REG_RO:  rd_val = i_Reg[i*WIDTH +: WIDTH];
          REG_WO:  rd_val = '0;
          default: rd_val = cell_val[i];
        endcase
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_dv_d   = 1'b0;
    if (i_Bus_CS && !i_Bus_Wr_Rd_n) begin
      rd_data_d = rd_val;
      rd_dv_d   = 1'b1;
    end
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      rd_data_q <= '0;
      rd_dv_q   <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_dv_q   <= rd_dv_d;
    end
  end

  assign o_Bus_Rd_Data = rd_data_q;
  assign o_Bus_Rd_DV   = rd_dv_q;

`ifdef BUS_REG_BANK_ERR_EN
  logic err_q, err_d;
  logic hit, bad_mode;

  always_comb begin
    hit      = 1'b0;
    bad_mode = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_Bus_Addr8 == ADDR_W'(i)) begin
        hit = 1'b1;
        if (i_Bus_Wr_Rd_n  && reg_mode(MODE_EXT, i) == REG_RO) bad_mode = 1'b1;
        if (!i_Bus_Wr_Rd_n && reg_mode(MODE_EXT, i) == REG_WO) bad_mode = 1'b1;
      end
    end
    err_d = i_Bus_CS && (!hit || bad_mode);
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) err_q <= 1'b0;
    else              err_q <= err_d;
  end

  assign o_Bus_Err = err_q;
`endif

endmodule
